// File: rtl/gcn_aggregation_scheduler.sv
// gcn_aggregation_scheduler
// Control-only sequencer for one GCN layer. It kicks the Transformation engine
// (FM x WM), waits for its done level, then walks the COO edge list twice (forward
// a->b, then reverse b->a) and finally every node onto itself. Each step issues
// one accumulate command, so the aggregation accumulator builds (A+I)*(FM*WM).
//
// Ports
//   clk, reset   clock / asynchronous active-high reset
//   start        begin a layer (honoured in IDLE or DONE only)
//   trans_start  one-cycle start pulse to the Transformation engine
//   trans_done   Transformation done level (honoured in TRANS only)
//   coo_address  edge index into COO memory (registered)
//   coo_in       [0]=node a, [1]=node b of the edge at coo_address
//   read_row     FM*WM product-memory row select (combinational)
//   agg_dst      accumulator destination row (combinational)
//   agg_en       accumulate fm_wm_row(read_row) into row agg_dst
//   agg_clear    one-cycle clear of all accumulator rows
//   err          sticky: out-of-range COO node index seen this run
//   done         layer complete, held until next start or reset
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// CLEAR | accumulator clear, err clear
// TRANS | trans_start pulse on first cycle, then wait for trans_done
// FWD   | edge walk, read row a, accumulate into row b
// REV   | edge walk, read row b, accumulate into row a
// SELF  | node walk, read row n, accumulate into row n
// DONE  | layer complete, waiting for restart
module gcn_aggregation_scheduler #(
    parameter int NUM_OF_NODES    = 6,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_NUM_OF_ROWS = 2,
    parameter int NODE_BW         = $clog2(NUM_OF_NODES),
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    output logic                                      trans_start,
    input  logic                                      trans_done,
    output logic [COO_BW-1:0]                         coo_address,
    input  logic [COO_NUM_OF_ROWS-1:0][NODE_BW-1:0]   coo_in,
    output logic [NODE_BW-1:0]                        read_row,
    output logic [NODE_BW-1:0]                        agg_dst,
    output logic                                      agg_en,
    output logic                                      agg_clear,
    output logic                                      err,
    output logic                                      done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_TRANS, S_FWD, S_REV, S_SELF, S_DONE
    } state_t;

    localparam logic [COO_BW-1:0]  EDGE_LAST  = COO_BW'(COO_NUM_OF_COLS - 1);
    localparam logic [NODE_BW-1:0] NODE_LAST  = NODE_BW'(NUM_OF_NODES - 1);
    // One bit wider so the limit is representable even for power-of-two node counts.
    localparam logic [NODE_BW:0]   NODE_LIMIT = (NODE_BW+1)'(NUM_OF_NODES);

    state_t              state_q, state_d;
    logic [COO_BW-1:0]   edge_idx_q, edge_idx_d;
    logic [NODE_BW-1:0]  node_q, node_d;

    logic agg_phase_q, agg_phase_d;
    logic trans_start_d, agg_clear_d, done_d, err_d;
    logic walk_phase, entry_ok;

    // state register and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            edge_idx_q <= '0;
            node_q     <= '0;
        end else begin
            state_q    <= state_d;
            edge_idx_q <= edge_idx_d;
            node_q     <= node_d;
        end
    end

    // next state
    always_comb begin
        state_d    = state_q;
        edge_idx_d = edge_idx_q;
        node_d     = node_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_TRANS;
            S_TRANS: begin
                if (trans_done) begin
                    state_d    = S_FWD;
                    edge_idx_d = '0;
                end
            end
            S_FWD: begin
                if (edge_idx_q == EDGE_LAST) begin
                    state_d    = S_REV;
                    edge_idx_d = '0;
                end else begin
                    edge_idx_d = edge_idx_q + 1'b1;
                end
            end
            S_REV: begin
                if (edge_idx_q == EDGE_LAST) begin
                    state_d    = S_SELF;
                    edge_idx_d = '0;
                    node_d     = '0;
                end else begin
                    edge_idx_d = edge_idx_q + 1'b1;
                end
            end
            S_SELF: begin
                if (node_q == NODE_LAST) begin
                    state_d = S_DONE;
                    node_d  = '0;
                end else begin
                    node_d = node_q + 1'b1;
                end
            end
            S_DONE:  if (start) state_d = S_CLEAR;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        walk_phase = (state_q == S_FWD) || (state_q == S_REV);
        entry_ok   = ({1'b0, coo_in[0]} < NODE_LIMIT) && ({1'b0, coo_in[1]} < NODE_LIMIT);

        read_row = '0;
        agg_dst  = '0;
        case (state_q)
            S_FWD: begin
                read_row = coo_in[0];
                agg_dst  = coo_in[1];
            end
            S_REV: begin
                read_row = coo_in[1];
                agg_dst  = coo_in[0];
            end
            S_SELF: begin
                read_row = node_q;
                agg_dst  = node_q;
            end
            default: ;
        endcase

        // The only same-cycle gating: a bad COO entry suppresses its accumulate.
        agg_en = agg_phase_q & (~walk_phase | entry_ok);

        trans_start_d = (state_q == S_CLEAR);
        agg_clear_d   = (state_d == S_CLEAR);
        done_d        = (state_d == S_DONE);
        agg_phase_d   = (state_d == S_FWD) || (state_d == S_REV) || (state_d == S_SELF);
        if (state_d == S_CLEAR) err_d = 1'b0;
        else                    err_d = err | (walk_phase & ~entry_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trans_start <= 1'b0;
            agg_clear   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            agg_phase_q <= 1'b0;
        end else begin
            trans_start <= trans_start_d;
            agg_clear   <= agg_clear_d;
            done        <= done_d;
            err         <= err_d;
            agg_phase_q <= agg_phase_d;
        end
    end

    assign coo_address = edge_idx_q;

endmodule

// File: tb/tb_gcn_aggregation_scheduler.sv
// Testbench for gcn_aggregation_scheduler. The COO memory is modelled as two small
// arrays read combinationally by coo_address; expected accumulate commands are
// derived from the edge list (forward pairs, reversed pairs, then the identity).
module tb_gcn_aggregation_scheduler;

    localparam int NN  = 6;
    localparam int NE  = 6;
    localparam int NB  = 3;
    localparam int CB  = 3;
    localparam int NST = 2*NE + NN;

    logic clk = 1'b0;
    logic reset, start, trans_done;
    logic trans_start, agg_en, agg_clear, err, done;
    logic [CB-1:0] coo_address;
    logic [1:0][NB-1:0] coo_in;
    logic [NB-1:0] read_row, agg_dst;

    logic [NB-1:0] mem_a [8];
    logic [NB-1:0] mem_b [8];

    int exp_en  [NST];
    int exp_rr  [NST];
    int exp_dst [NST];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        coo_in[0] = mem_a[coo_address];
        coo_in[1] = mem_b[coo_address];
    end

    gcn_aggregation_scheduler #(
        .NUM_OF_NODES(NN), .COO_NUM_OF_COLS(NE), .COO_NUM_OF_ROWS(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .trans_start(trans_start),
        .trans_done(trans_done), .coo_address(coo_address), .coo_in(coo_in),
        .read_row(read_row), .agg_dst(agg_dst), .agg_en(agg_en),
        .agg_clear(agg_clear), .err(err), .done(done)
    );

    task automatic load_ring();
        for (int e = 0; e < 8; e++) begin
            mem_a[e] = NB'(e % NN);
            mem_b[e] = NB'((e + 1) % NN);
        end
    endtask

    // Reference: every edge contributes a->b and b->a, every node contributes n->n;
    // a step referencing a node outside 0..NN-1 contributes nothing.
    task automatic build_expected(output int n_en, output bit any_bad);
        int k, a, b;
        k = 0; n_en = 0; any_bad = 0;
        for (int p = 0; p < 2; p++) begin
            for (int e = 0; e < NE; e++) begin
                a = int'(mem_a[e]);
                b = int'(mem_b[e]);
                exp_en[k]  = (a < NN && b < NN) ? 1 : 0;
                exp_rr[k]  = (p == 0) ? a : b;
                exp_dst[k] = (p == 0) ? b : a;
                if (exp_en[k] == 1) n_en++;
                else any_bad = 1;
                k++;
            end
        end
        for (int n = 0; n < NN; n++) begin
            exp_en[k] = 1; exp_rr[k] = n; exp_dst[k] = n;
            n_en++; k++;
        end
    endtask

    // Called at a negedge while the DUT is in IDLE or DONE; returns at the
    // negedge of the first DONE cycle.
    task automatic run_layer(input int delay, input bit spurious);
        int n_en_exp, seen_en;
        bit bad_exp;
        build_expected(n_en_exp, bad_exp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({agg_clear, done, err, trans_start} !== 4'b1000) begin
            errors++;
            $display("FAIL clear_cycle {clear,done,err,tstart} got %b want 1000", {agg_clear, done, err, trans_start});
        end
        @(negedge clk);
        checks++;
        if ({trans_start, agg_clear, agg_en} !== 3'b100) begin
            errors++;
            $display("FAIL trans_start_pulse {tstart,clear,en} got %b want 100", {trans_start, agg_clear, agg_en});
        end
        trans_done = (delay == 0);
        for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({trans_start, agg_en, done, agg_clear} !== 4'b0000) begin
                errors++;
                $display("FAIL trans_wait cycle %0d {tstart,en,done,clear} got %b want 0000", i, {trans_start, agg_en, done, agg_clear});
            end
            trans_done = (i == delay);
            if (spurious && i == 1) start = 1'b1;
        end
        seen_en = 0;
        for (int k = 0; k < NST; k++) begin
            @(negedge clk);
            checks++;
            if (agg_en !== exp_en[k][0]) begin
                errors++;
                $display("FAIL agg_en step %0d got %b want %0d", k, agg_en, exp_en[k]);
            end
            if (exp_en[k] == 1) begin
                checks++;
                if (read_row !== NB'(exp_rr[k]) || agg_dst !== NB'(exp_dst[k])) begin
                    errors++;
                    $display("FAIL agg_pair step %0d got (%0d->%0d) want (%0d->%0d)", k, read_row, agg_dst, exp_rr[k], exp_dst[k]);
                end
            end
            checks++;
            if ({trans_start, agg_clear, done} !== 3'b000) begin
                errors++;
                $display("FAIL walk_ctrl step %0d {tstart,clear,done} got %b want 000", k, {trans_start, agg_clear, done});
            end
            if (agg_en === 1'b1) seen_en++;
            start      = spurious && (k == 2);
            trans_done = spurious && (k == 4);
        end
        @(negedge clk);
        start = 1'b0;
        trans_done = 1'b0;
        checks++;
        if (done !== 1'b1 || agg_en !== 1'b0) begin
            errors++;
            $display("FAIL done_rise done=%b en=%b want done=1 en=0", done, agg_en);
        end
        checks++;
        if (err !== bad_exp) begin
            errors++;
            $display("FAIL err_at_done got %b want %b", err, bad_exp);
        end
        checks++;
        if (seen_en != n_en_exp) begin
            errors++;
            $display("FAIL agg_en_count got %0d want %0d", seen_en, n_en_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; trans_done = 1'b0;
        load_ring();
        repeat (2) @(negedge clk);
        checks++;
        if ({trans_start, agg_en, agg_clear, err, done, coo_address, read_row, agg_dst} !== '0) begin
            errors++;
            $display("FAIL reset_state got ts=%b en=%b clr=%b err=%b done=%b addr=%0d rr=%0d dst=%0d want all 0",
                     trans_start, agg_en, agg_clear, err, done, coo_address, read_row, agg_dst);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({trans_start, agg_en, agg_clear, done} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 0000", {trans_start, agg_en, agg_clear, done});
        end
    endtask

    task automatic test_nominal();
        load_ring();
        run_layer(5, 1'b0);
    endtask

    task automatic test_bad_index();
        load_ring();
        mem_a[3] = 3'd2;
        mem_b[3] = 3'd7;
        run_layer(5, 1'b0);
        load_ring();
        run_layer(3, 1'b0);
    endtask

    task automatic test_back_to_back();
        load_ring();
        run_layer(2, 1'b0);
        run_layer(2, 1'b0);
    endtask

    task automatic test_slow_transform();
        load_ring();
        run_layer(200, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        load_ring();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        trans_done = 1'b1;
        @(negedge clk);
        trans_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (coo_address !== 3'd2 || agg_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_edge addr=%0d en=%b want addr=2 en=1", coo_address, agg_en);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({trans_start, agg_en, agg_clear, err, done, coo_address, read_row, agg_dst} !== '0) begin
            errors++;
            $display("FAIL async_reset got ts=%b en=%b clr=%b err=%b done=%b addr=%0d rr=%0d dst=%0d want all 0",
                     trans_start, agg_en, agg_clear, err, done, coo_address, read_row, agg_dst);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({done, agg_clear, trans_start, agg_en, coo_address} !== '0) begin
                errors++;
                $display("FAIL stay_idle cycle %0d done=%b clr=%b ts=%b en=%b addr=%0d want all 0",
                         i, done, agg_clear, trans_start, agg_en, coo_address);
            end
        end
    endtask

    task automatic test_spurious();
        load_ring();
        trans_done = 1'b1;
        @(negedge clk);
        trans_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({trans_start, agg_clear, agg_en, done} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_trans_done cycle %0d got %b want 0000", i, {trans_start, agg_clear, agg_en, done});
            end
        end
        run_layer(5, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int e = 0; e < 8; e++) begin
                mem_a[e] = NB'($urandom_range(0, NN-1));
                mem_b[e] = NB'($urandom_range(0, NN-1));
                if ($urandom_range(0, 7) == 0) mem_b[e] = NB'($urandom_range(NN, 7));
            end
            run_layer(int'($urandom_range(0, 8)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_index();
        test_back_to_back();
        test_slow_transform();
        test_reset_mid_run();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
